regfile_sb: RTL and testbench

- Parametrised integer register file for the NPC core, with N combinational read ports, one write port, optional write-to-read bypass and a per-register pending-write scoreboard.
- Decode marks destination registers pending at issue; writeback writes data and clears the pending mark.
- Read ports report whether their operand is ready, so the pipeline stalls on RAW hazards without separate hazard logic.
- x0 is hardwired to zero.

---
 rtl/npc_pkg.sv | 15 +
 rtl/regfile_sb_rport.sv | 39 +++
 rtl/regfile_sb.sv | 99 +++++++++
 tb/tb_regfile_sb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared NPC core constants, types and pending-counter helper
package npc_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef logic [4:0]          reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

    // Largest value a pending counter of the given width can hold.
    function automatic int pend_max(input int pend_w);
        return (1 << pend_w) - 1;
    endfunction

endpackage

// File: rtl/regfile_sb_rport.sv
// rtl/regfile_sb_rport.sv - one read port: register mux, writeback bypass, operand-ready
module regfile_sb_rport
    import npc_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = NREG_DEF,
    parameter int PEND_W   = 2,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic [AW-1:0]              addr,
    input  logic [NUM_REGS*XLEN-1:0]   regs_flat,
    input  logic [NUM_REGS*PEND_W-1:0] pend_flat,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    output logic [XLEN-1:0]            data,
    output logic                       ready
);

    logic [PEND_W-1:0] pend_cur;
    logic              hit;

    // x0 reads as ready zero; a same-cycle writeback resolves exactly one pending write
    always_comb begin
        pend_cur = pend_flat[addr*PEND_W +: PEND_W];
        hit      = (BYPASS != 0) && wr_en && (wr_addr == addr);
        data     = regs_flat[addr*XLEN +: XLEN];
        ready    = (pend_cur == '0);
        if (addr == '0) begin
            data  = '0;
            ready = 1'b1;
        end else if (hit) begin
            data  = wr_data;
            ready = (pend_cur <= PEND_W'(1));
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with write bypass and pending-write scoreboard
module regfile_sb
    import npc_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_REGS = NREG_DEF,
    parameter int NR_RD    = 2,
    parameter int BYPASS   = 1,
    parameter int PEND_W   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NR_RD*$clog2(NUM_REGS)-1:0] rd_addr,
    output logic [NR_RD*XLEN-1:0]         rd_data,
    output logic [NR_RD-1:0]              rd_ready,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]   wr_addr,
    input  logic [XLEN-1:0]               wr_data,
    input  logic                          iss_en,
    input  logic [$clog2(NUM_REGS)-1:0]   iss_rd,
    output logic                          iss_full,
    input  logic                          flush
);

    localparam int                AW       = $clog2(NUM_REGS);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(pend_max(PEND_W));

    logic [XLEN-1:0]            regs     [NUM_REGS];
    logic [PEND_W-1:0]          pend     [NUM_REGS];
    logic [PEND_W-1:0]          pend_nxt [NUM_REGS];
    logic [NUM_REGS*XLEN-1:0]   regs_flat;
    logic [NUM_REGS*PEND_W-1:0] pend_flat;

    // Register storage; x0 is never written so it stays zero from reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Scoreboard next state: flush wins, then issue+writeback to the same reg cancels out
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) pend_nxt[r] = pend[r];
        if (flush) begin
            for (int r = 0; r < NUM_REGS; r++) pend_nxt[r] = '0;
        end else if (!(iss_en && wr_en && iss_rd == wr_addr)) begin
            if (iss_en && iss_rd != '0 && pend[iss_rd] != PEND_MAX)
                pend_nxt[iss_rd] = pend[iss_rd] + PEND_W'(1);
            if (wr_en && wr_addr != '0 && pend[wr_addr] != '0)
                pend_nxt[wr_addr] = pend[wr_addr] - PEND_W'(1);
        end
    end

    // Scoreboard state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) pend[r] <= pend_nxt[r];
        end
    end

    // Flatten storage so each read port can index it with a plain part-select
    always_comb begin
        regs_flat = '0;
        pend_flat = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            regs_flat[r*XLEN +: XLEN]     = regs[r];
            pend_flat[r*PEND_W +: PEND_W] = pend[r];
        end
    end

    assign iss_full = (pend[iss_rd] == PEND_MAX) && (iss_rd != '0);

    for (genvar i = 0; i < NR_RD; i++) begin : g_rport
        regfile_sb_rport #(
            .XLEN     (XLEN),
            .NUM_REGS (NUM_REGS),
            .PEND_W   (PEND_W),
            .BYPASS   (BYPASS),
            .AW       (AW)
        ) u_rport (
            .addr      (rd_addr[i*AW +: AW]),
            .regs_flat (regs_flat),
            .pend_flat (pend_flat),
            .wr_en     (wr_en),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .data      (rd_data[i*XLEN +: XLEN]),
            .ready     (rd_ready[i])
        );
    end

    iss_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(iss_en && iss_full && !flush));

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - randomized and directed self-checking bench for regfile_sb
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NR = 2;
    localparam int AW = 5;
    localparam int PW = 2;
    localparam int PMAX = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NR*AW-1:0]   rd_addr;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [XLEN-1:0]    wr_data;
    logic               iss_en;
    logic [AW-1:0]      iss_rd;
    logic               flush;

    logic [NR*XLEN-1:0] rd_data_b, rd_data_n;
    logic [NR-1:0]      rd_ready_b, rd_ready_n;
    logic               iss_full_b, iss_full_n;

    logic [XLEN-1:0]    mreg  [NREGS];
    int                 mpend [NREGS];
    int                 n_cmp = 0;
    int                 n_fail = 0;
    bit                 chk_en = 1'b0;

    regfile_sb #(.XLEN(XLEN), .NUM_REGS(NREGS), .NR_RD(NR), .BYPASS(1), .PEND_W(PW)) u_byp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_ready(rd_ready_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd),
        .iss_full(iss_full_b), .flush(flush));

    regfile_sb #(.XLEN(XLEN), .NUM_REGS(NREGS), .NR_RD(NR), .BYPASS(0), .PEND_W(PW)) u_nob (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_ready(rd_ready_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd),
        .iss_full(iss_full_n), .flush(flush));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_data(input int a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && wr_en && int'(wr_addr) == a) return wr_data;
        return mreg[a];
    endfunction

    function automatic logic [31:0] m_ready(input int a, input bit byp);
        if (a == 0 || mpend[a] == 0) return 32'd1;
        if (byp && wr_en && int'(wr_addr) == a && mpend[a] == 1) return 32'd1;
        return 32'd0;
    endfunction

    task automatic compare_all();
        for (int p = 0; p < NR; p++) begin
            int a;
            a = int'(rd_addr[p*AW +: AW]);
            chk($sformatf("byp.data[%0d] x%0d", p, a), rd_data_b[p*XLEN +: XLEN], m_data(a, 1'b1));
            chk($sformatf("byp.ready[%0d] x%0d", p, a), 32'(rd_ready_b[p]), m_ready(a, 1'b1));
            chk($sformatf("nob.data[%0d] x%0d", p, a), rd_data_n[p*XLEN +: XLEN], m_data(a, 1'b0));
            chk($sformatf("nob.ready[%0d] x%0d", p, a), 32'(rd_ready_n[p]), m_ready(a, 1'b0));
        end
        chk("byp.iss_full", 32'(iss_full_b), 32'(iss_rd != 0 && mpend[iss_rd] == PMAX));
        chk("nob.iss_full", 32'(iss_full_n), 32'(iss_rd != 0 && mpend[iss_rd] == PMAX));
    endtask

    // Every settled cycle: both DUTs against the reference model
    always @(negedge clk) if (chk_en && rst_n) compare_all();

    // Reference model: architectural effect of one clock edge
    always @(posedge clk) begin
        if (rst_n) begin
            if (wr_en && wr_addr != 0) mreg[wr_addr] = wr_data;
            if (flush) begin
                for (int r = 0; r < NREGS; r++) mpend[r] = 0;
            end else if (!(iss_en && wr_en && iss_rd == wr_addr)) begin
                if (iss_en && iss_rd != 0 && mpend[iss_rd] < PMAX) mpend[iss_rd]++;
                if (wr_en && wr_addr != 0 && mpend[wr_addr] > 0) mpend[wr_addr]--;
            end
        end
    end

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            mreg[r]  = '0;
            mpend[r] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        iss_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    initial begin
        model_reset();
        idle();
        rd_addr = '0; wr_addr = '0; wr_data = '0; iss_rd = '0;

        // Reset values
        #2;
        chk("rst.iss_full", 32'(iss_full_b), 32'd0);
        chk("rst.ready", 32'(rd_ready_b), 32'd3);
        #10;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        // Every address on both ports after reset
        for (int a = 0; a < NREGS; a++) begin
            set_rd(a, NREGS - 1 - a);
            #1;
            chk($sformatf("init.data x%0d", a), rd_data_b[31:0], 32'h0);
            chk($sformatf("init.data x%0d", NREGS - 1 - a), rd_data_b[63:32], 32'h0);
            chk($sformatf("init.ready x%0d", a), 32'(rd_ready_b), 32'd3);
        end
        tick();

        // x0 write is discarded
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF; set_rd(0, 0);
        #1 chk("x0.bypass", rd_data_b[31:0], 32'h0);
        tick(); idle();
        chk("x0.after", rd_data_b[31:0], 32'h0);

        // RAW on x5 with and without bypass
        iss_en = 1'b1; iss_rd = 5'd5;
        tick(); idle(); set_rd(5, 5);
        #1 chk("x5.pending.byp", 32'(rd_ready_b), 32'd0);
        chk("x5.pending.nob", 32'(rd_ready_n), 32'd0);
        tick(); tick();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678;
        #1 chk("x5.wb.byp.ready", 32'(rd_ready_b), 32'd3);
        chk("x5.wb.byp.data", rd_data_b[31:0], 32'h1234_5678);
        chk("x5.wb.nob.ready", 32'(rd_ready_n), 32'd0);
        chk("x5.wb.nob.data", rd_data_n[31:0], 32'h0);
        tick(); idle();
        chk("x5.next.nob.ready", 32'(rd_ready_n), 32'd3);
        chk("x5.next.nob.data", rd_data_n[63:32], 32'h1234_5678);

        // Saturation on x7 and unsolicited writeback
        iss_en = 1'b1; iss_rd = 5'd7;
        tick(); tick(); tick();
        iss_en = 1'b0;
        #1 chk("x7.full.byp", 32'(iss_full_b), 32'd1);
        chk("x7.full.nob", 32'(iss_full_n), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'(k);
            tick();
        end
        idle(); set_rd(7, 7);
        #1 chk("x7.drained.ready", 32'(rd_ready_n), 32'd3);
        chk("x7.drained.full", 32'(iss_full_b), 32'd0);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5;
        tick(); idle();
        chk("x7.extra.data", rd_data_n[31:0], 32'hA5);
        chk("x7.extra.ready", 32'(rd_ready_b), 32'd3);

        // Same-cycle issue and writeback on x9
        iss_en = 1'b1; iss_rd = 5'd9;
        tick();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        tick(); idle(); set_rd(9, 9);
        #1 chk("x9.ready", 32'(rd_ready_b), 32'd0);
        chk("x9.data", rd_data_n[31:0], 32'h99);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9A;
        tick(); idle();

        // Flush clears x3/x4 and ignores the concurrent x6 issue
        iss_en = 1'b1; iss_rd = 5'd3; tick();
        iss_rd = 5'd4; tick();
        iss_rd = 5'd6; flush = 1'b1; tick();
        idle(); set_rd(3, 4);
        #1 chk("flush.x3x4", 32'(rd_ready_n), 32'd3);
        set_rd(6, 6);
        #1 chk("flush.x6", 32'(rd_ready_n), 32'd3);

        // Asynchronous reset mid-cycle
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hCAFE; tick();
        idle(); iss_en = 1'b1; iss_rd = 5'd10; tick();
        idle(); set_rd(10, 10);
        #1 chk("x10.data", rd_data_b[31:0], 32'hCAFE);
        chk("x10.pending", 32'(rd_ready_b), 32'd0);
        chk_en = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1 chk("rst.mid.data", rd_data_b[31:0], 32'h0);
        chk("rst.mid.ready", 32'(rd_ready_n), 32'd3);
        chk("rst.mid.full", 32'(iss_full_b), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();
        chk("x10.after.rst", rd_data_n[63:32], 32'h0);

        // Randomized traffic concentrated on a few registers to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            set_rd($urandom_range(0, 7), $urandom_range(0, 31));
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = AW'($urandom_range(0, 7));
            wr_data = $urandom;
            iss_en  = ($urandom_range(0, 9) < 4);
            iss_rd  = AW'($urandom_range(0, 7));
            flush   = ($urandom_range(0, 99) < 3);
            if (!flush && iss_rd != 0 && mpend[iss_rd] == PMAX) iss_en = 1'b0;
            tick();
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
